// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_pkg
// Description : Shared types and constants for the adder-result UART
//               transmitter (state encoding, frame geometry, line level).
// Revision    : 1.0 - initial release
// ============================================================================
package sum_uart_pkg;

    // Transmitter states, in the order they occur within a frame.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Payload width of one frame.
    localparam int DATA_BITS = 8;

    // Line level while no frame is in progress (UART mark).
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage : sum_uart_pkg
`default_nettype wire

// File: rtl/sum_uart_tx_baud.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter for the UART transmitter. Counts
//               0..CLKS_PER_BIT-1 while enabled and flags the final cycle of
//               each bit period (tick) and the cycle before it (tick_early).
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic tick_early
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] c_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_count;

    // Free-running bit counter; held at zero whenever the line is idle so
    // the first bit of every frame gets a full period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick       = en && (r_count == c_LAST);
    // Lets the parent register a flag that lands exactly on the last cycle.
    assign tick_early = en && (r_count == c_PRE_LAST);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_tx
// Description : Captures an 8-bit adder sum over a valid/ready handshake and
//               serialises it LSB first as an 8N1 frame (8E1 when PARITY_EN).
//               All outputs are registered; tx drops one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] c_LAST_BIT = IW'(DATA_BITS - 1);

    // Bit periods shorter than two cycles leave no room for the
    // one-cycle-early frame_done registration.
    generate
        if (CLKS_PER_BIT < 2) begin : g_param_check
            $error("sum_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_tick;
    logic                 w_tick_early;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .en         (r_busy),
        .tick       (w_tick),
        .tick_early (w_tick_early)
    );

    // Frame sequencer: handshake capture, bit shifting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_idx    <= '0;
            r_tx         <= IDLE_LEVEL;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Raised one cycle ahead so it is high during the final stop cycle.
            r_frame_done <= (r_state == ST_STOP) && w_tick_early;

            case (r_state)
                ST_IDLE: begin
                    if (s_valid && r_ready) begin
                        r_shift   <= s_data;
                        r_parity  <= even_parity(s_data);
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_LAST_BIT) begin
                            if (PARITY_EN) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= IDLE_LEVEL;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule : sum_uart_tx
`default_nettype wire

// File: tb/tb_sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_uart_tx
// Description : Self-checking bench for sum_uart_tx. Three instances cover
//               (4 clk/bit, no parity), (4 clk/bit, even parity) and the
//               2 clk/bit boundary. Expected line waveforms come from a
//               bit-list frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_data     [3];
    logic       s_valid    [3];
    logic       s_ready    [3];
    logic       tx         [3];
    logic       busy       [3];
    logic       frame_done [3];

    int cfg_n [3] = '{4, 4, 2};
    int cfg_p [3] = '{0, 1, 0};

    int n_checks = 0;
    int n_fail   = 0;

    sum_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    sum_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    sum_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    // Single comparison point.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one byte on instance d and checks every cycle of the frame plus
    // the idle cycle after it. poke_at >= 0 injects new data/valid mid-frame;
    // keep_valid leaves s_valid high and loads next_data for a back-to-back send.
    task automatic run_frame(input int d, input logic [7:0] data, input int poke_at,
                             input bit keep_valid, input logic [7:0] next_data);
        int   n;
        int   nbits;
        int   len;
        int   waited;
        logic exp_bits [11];
        n     = cfg_n[d];
        nbits = 10 + cfg_p[d];
        len   = nbits * n;

        // Frame model: start, 8 data bits LSB first, optional even parity, stop.
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i + 1] = data[i];
        if (cfg_p[d] != 0) exp_bits[9] = (($countones(data) % 2) == 1);
        exp_bits[nbits - 1] = 1'b1;

        s_data[d]  = data;
        s_valid[d] = 1'b1;
        waited = 0;
        while (!s_ready[d] && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready[d]) begin
            check_eq($sformatf("ready_timeout d%0d", d), 32'd0, 32'd1);
            s_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!keep_valid) s_valid[d] = 1'b0;

        for (int k = 0; k < len; k++) begin
            check_eq($sformatf("tx d%0d data %0h k%0d", d, data, k), 32'(tx[d]), 32'(exp_bits[k / n]));
            check_eq($sformatf("busy d%0d k%0d", d, k), 32'(busy[d]), 32'd1);
            check_eq($sformatf("s_ready d%0d k%0d", d, k), 32'(s_ready[d]), 32'd0);
            check_eq($sformatf("frame_done d%0d k%0d", d, k), 32'(frame_done[d]), 32'(k == len - 1));
            if (poke_at >= 0 && k == poke_at) begin
                s_data[d]  = 8'h00;
                s_valid[d] = 1'b1;
            end else if (poke_at >= 0 && k == poke_at + 1) begin
                s_valid[d] = 1'b0;
            end
            if (keep_valid && k == n) s_data[d] = next_data;
            @(posedge clk); #1;
        end

        check_eq($sformatf("post s_ready d%0d", d), 32'(s_ready[d]), 32'd1);
        check_eq($sformatf("post busy d%0d", d), 32'(busy[d]), 32'd0);
        check_eq($sformatf("post tx d%0d", d), 32'(tx[d]), 32'd1);
        check_eq($sformatf("post frame_done d%0d", d), 32'(frame_done[d]), 32'd0);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            s_data[d]  = 8'h00;
            s_valid[d] = 1'b0;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("reset tx d%0d", d), 32'(tx[d]), 32'd1);
            check_eq($sformatf("reset s_ready d%0d", d), 32'(s_ready[d]), 32'd1);
            check_eq($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'd0);
            check_eq($sformatf("reset frame_done d%0d", d), 32'(frame_done[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Quiet line with no valid.
        for (int c = 0; c < 20; c++) begin
            check_eq($sformatf("idle tx c%0d", c), 32'(tx[0]), 32'd1);
            check_eq($sformatf("idle s_ready c%0d", c), 32'(s_ready[0]), 32'd1);
            check_eq($sformatf("idle busy c%0d", c), 32'(busy[0]), 32'd0);
            check_eq($sformatf("idle frame_done c%0d", c), 32'(frame_done[0]), 32'd0);
            @(posedge clk); #1;
        end

        // 0x20 + 0x15.
        run_frame(0, 8'h35, -1, 1'b0, 8'h00);

        // Parity frames back to back with valid held.
        run_frame(1, 8'h01, -1, 1'b1, 8'hFF);
        run_frame(1, 8'hFF, -1, 1'b0, 8'h00);

        // Data change and extra valid while busy.
        run_frame(0, 8'hA5, 10, 1'b0, 8'h00);

        // Reset during data bit 3 of 0x5A.
        s_data[0]  = 8'h5A;
        s_valid[0] = 1'b1;
        check_eq("abort pre s_ready", 32'(s_ready[0]), 32'd1);
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        repeat (17) begin
            @(posedge clk); #1;
        end
        check_eq("abort bit3 tx", 32'(tx[0]), 32'((8'h5A >> 3) & 8'h01));
        rst        = 1'b1;
        s_valid[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("abort tx", 32'(tx[0]), 32'd1);
        check_eq("abort s_ready", 32'(s_ready[0]), 32'd1);
        check_eq("abort busy", 32'(busy[0]), 32'd0);
        check_eq("abort frame_done", 32'(frame_done[0]), 32'd0);
        rst        = 1'b0;
        s_valid[0] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            check_eq($sformatf("after abort frame_done c%0d", c), 32'(frame_done[0]), 32'd0);
            check_eq($sformatf("after abort tx c%0d", c), 32'(tx[0]), 32'd1);
            @(posedge clk); #1;
        end
        run_frame(0, 8'h5A, -1, 1'b0, 8'h00);

        // Shortest legal bit period.
        run_frame(2, 8'h80, -1, 1'b0, 8'h00);

        // Random payloads on every configuration.
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 3; r++) begin
                b = 8'($urandom_range(0, 255));
                run_frame(d, b, -1, 1'b0, 8'h00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sum_uart_tx
`default_nettype wire
